dma_sync_fifo: RTL and testbench

// - Parametrised single-clock FIFO for the E203 DMA datapath; buffers beats between the bus-read and bus-write engines.
// - Adds over the base FIFO: configurable width/depth, occupancy count, almost-full/almost-empty thresholds, synchronous flush, push-while-full pass-through.
// - Show-ahead read: rd_data always presents the head entry, with no read latency.

---
 rtl/dma_pkg.sv | 7 +
 rtl/dma_fifo_ram.sv | 27 ++
 rtl/dma_sync_fifo.sv | 103 ++++++++++
 tb/tb_dma_sync_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared DMA datapath package: beat width, default FIFO depth and beat type.
package dma_pkg;
    localparam int DMA_DATA_W     = 32;
    localparam int DMA_FIFO_DEPTH = 512;

    typedef logic [DMA_DATA_W-1:0] dma_beat_t;
endpackage

// File: rtl/dma_fifo_ram.sv
// Simple dual-port storage array for the DMA FIFO: synchronous write, asynchronous read.
// Kept as its own module so a vendor RAM macro can replace it.
module dma_fifo_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; only written entries are ever presented as valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dma_sync_fifo.sv
// Single-clock show-ahead FIFO between the DMA bus-read and bus-write engines.
// Define DMA_FIFO_ERR_EN to add sticky overflow/underflow flag ports.
module dma_sync_fifo
    import dma_pkg::*;
#(
    parameter int WIDTH     = DMA_DATA_W,
    parameter int DEPTH     = DMA_FIFO_DEPTH,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_req,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_req,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level
`ifdef DMA_FIFO_ERR_EN
    ,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0] LVL_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] LVL_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_AF    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] LVL_AE    = (AW+1)'(AE_THRESH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push;
    logic        pop;
    logic        ram_we;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop    = rd_req & ~empty;
    assign push   = wr_req & (~full | pop);
    assign ram_we = push & ~clr & rst_n;

    assign full         = (level == LVL_DEPTH);
    assign empty        = (level == '0);
    assign almost_full  = (level >= LVL_AF);
    assign almost_empty = (level <= LVL_AE);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + LVL_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + LVL_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

`ifdef DMA_FIFO_ERR_EN
    // Sticky until the next reset or flush so software can see any dropped request.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_req && full && !pop) begin
                overflow <= 1'b1;
            end
            if (rd_req && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

    dma_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_dma_sync_fifo.sv
// Self-checking bench for dma_sync_fifo (DEPTH=8) against a queue-based reference model.
module tb_dma_sync_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        wr_req;
    logic [31:0] wr_data;
    logic        rd_req;
    logic [31:0] rd_data;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  level;
`ifdef DMA_FIFO_ERR_EN
    logic        overflow;
    logic        underflow;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] q [$];
    logic        m_ovf;
    logic        m_udf;

    always #5 clk = ~clk;

    dma_sync_fifo #(
        .WIDTH     (32),
        .DEPTH     (8),
        .AF_THRESH (6),
        .AE_THRESH (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr_req       (wr_req),
        .wr_data      (wr_data),
        .rd_req       (rd_req),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level)
`ifdef DMA_FIFO_ERR_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    // One clock with the given requests; the model follows the FIFO rules on the same edge.
    task automatic cycle(input logic w, input logic [31:0] wd, input logic r, input logic c);
        bit p_pop;
        bit p_push;
        wr_req  = w;
        wr_data = wd;
        rd_req  = r;
        clr     = c;
        @(posedge clk);
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            p_pop  = r && (q.size() > 0);
            p_push = w && ((q.size() < 8) || p_pop);
            if (w && !p_push) m_ovf = 1'b1;
            if (r && !p_pop)  m_udf = 1'b1;
            if (p_pop)  void'(q.pop_front());
            if (p_push) q.push_back(wd);
        end
        #1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        @(posedge clk); #1;
        checks += 5;
        if (level !== 4'd0)      begin errors++; $display("[TB] FAIL reset_level got %0d want 0", level); end
        if (empty !== 1'b1)      begin errors++; $display("[TB] FAIL reset_empty got %b want 1", empty); end
        if (almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_aempty got %b want 1", almost_empty); end
        if (full !== 1'b0)       begin errors++; $display("[TB] FAIL reset_full got %b want 0", full); end
        if (almost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_afull got %b want 0", almost_full); end
`ifdef DMA_FIFO_ERR_EN
        checks++;
        if ({overflow, underflow} !== 2'b00) begin errors++; $display("[TB] FAIL reset_err got %b%b want 00", overflow, underflow); end
`endif
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 32'(i), 1'b0, 1'b0);
            checks += 5;
            if (level !== 4'(i)) begin errors++; $display("[TB] FAIL fill_level got %0d want %0d", level, i); end
            if (almost_empty !== (i <= 1)) begin errors++; $display("[TB] FAIL fill_aempty lvl %0d got %b", i, almost_empty); end
            if (almost_full !== (i >= 6))  begin errors++; $display("[TB] FAIL fill_afull lvl %0d got %b", i, almost_full); end
            if (full !== (i == 8))         begin errors++; $display("[TB] FAIL fill_full lvl %0d got %b", i, full); end
            if (rd_data !== 32'h1)         begin errors++; $display("[TB] FAIL fill_head got %h want 1", rd_data); end
        end
        cycle(1'b1, 32'h9, 1'b0, 1'b0);
        checks += 3;
        if (level !== 4'd8)  begin errors++; $display("[TB] FAIL fill_drop_level got %0d want 8", level); end
        if (full !== 1'b1)   begin errors++; $display("[TB] FAIL fill_drop_full got %b want 1", full); end
        if (rd_data !== 32'h1) begin errors++; $display("[TB] FAIL fill_drop_head got %h want 1", rd_data); end
`ifdef DMA_FIFO_ERR_EN
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL fill_overflow got %b want 1", overflow); end
`endif
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) begin
                checks++;
                if (rd_data !== 32'(i)) begin errors++; $display("[TB] FAIL drain_data pop %0d got %h want %h", i, rd_data, i); end
            end
            cycle(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (level !== 4'(q.size())) begin errors++; $display("[TB] FAIL drain_level got %0d want %0d", level, q.size()); end
        end
        checks += 2;
        if (empty !== 1'b1)  begin errors++; $display("[TB] FAIL drain_empty got %b want 1", empty); end
        if (level !== 4'd0)  begin errors++; $display("[TB] FAIL drain_final_level got %0d want 0", level); end
`ifdef DMA_FIFO_ERR_EN
        checks++;
        if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL drain_underflow got %b want 1", underflow); end
`endif
    endtask

    task automatic test_pass_through();
        while (q.size() < 8) cycle(1'b1, $urandom, 1'b0, 1'b0);
        cycle(1'b1, 32'hA5, 1'b1, 1'b0);
        checks += 4;
        if (level !== 4'd8)   begin errors++; $display("[TB] FAIL pass_level got %0d want 8", level); end
        if (full !== 1'b1)    begin errors++; $display("[TB] FAIL pass_full got %b want 1", full); end
        if (rd_data !== q[0]) begin errors++; $display("[TB] FAIL pass_head got %h want %h", rd_data, q[0]); end
        if (q[7] !== 32'hA5)  begin errors++; $display("[TB] FAIL pass_model_tail got %h want a5", q[7]); end
        // Walk to the tail to prove 0xA5 was stored behind the older entries.
        while (q.size() > 1) cycle(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (rd_data !== 32'hA5) begin errors++; $display("[TB] FAIL pass_tail got %h want a5", rd_data); end
    endtask

    task automatic test_wrap();
        while (q.size() < 3) cycle(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (rd_data !== q[0]) begin errors++; $display("[TB] FAIL wrap_data cyc %0d got %h want %h", i, rd_data, q[0]); end
            cycle(1'b1, $urandom, 1'b1, 1'b0);
            checks++;
            if (level !== 4'd3) begin errors++; $display("[TB] FAIL wrap_level cyc %0d got %0d want 3", i, level); end
        end
    endtask

    task automatic test_flush();
        while (q.size() < 5) cycle(1'b1, $urandom, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        checks += 2;
        if (level !== 4'd0) begin errors++; $display("[TB] FAIL flush_level got %0d want 0", level); end
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL flush_empty got %b want 1", empty); end
`ifdef DMA_FIFO_ERR_EN
        checks++;
        if ({overflow, underflow} !== 2'b00) begin errors++; $display("[TB] FAIL flush_err got %b%b want 00", overflow, underflow); end
`endif
        cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        checks += 2;
        if (level !== 4'd1) begin errors++; $display("[TB] FAIL flush_after_level got %0d want 1", level); end
        if (rd_data !== 32'h1234_5678) begin errors++; $display("[TB] FAIL flush_after_head got %h want 12345678", rd_data); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
            checks += 5;
            if (level !== 4'(q.size()))          begin errors++; $display("[TB] FAIL rand_level cyc %0d got %0d want %0d", i, level, q.size()); end
            if (empty !== (q.size() == 0))       begin errors++; $display("[TB] FAIL rand_empty cyc %0d got %b", i, empty); end
            if (full !== (q.size() == 8))        begin errors++; $display("[TB] FAIL rand_full cyc %0d got %b", i, full); end
            if (almost_full !== (q.size() >= 6)) begin errors++; $display("[TB] FAIL rand_afull cyc %0d got %b", i, almost_full); end
            if (almost_empty !== (q.size() <= 1)) begin errors++; $display("[TB] FAIL rand_aempty cyc %0d got %b", i, almost_empty); end
            if (q.size() > 0) begin
                checks++;
                if (rd_data !== q[0]) begin errors++; $display("[TB] FAIL rand_data cyc %0d got %h want %h", i, rd_data, q[0]); end
            end
`ifdef DMA_FIFO_ERR_EN
            checks++;
            if ({overflow, underflow} !== {m_ovf, m_udf}) begin errors++; $display("[TB] FAIL rand_err cyc %0d got %b%b want %b%b", i, overflow, underflow, m_ovf, m_udf); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_pass_through();
        test_wrap();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
